// File: rtl/spi_flash_seq_if.sv
// spi_flash_seq_if
//   Bundles the request/response handshake and the APB master bus of
//   spi_flash_seq into one port.
//   master modport: sequencer side. It drives ReqReady, RspValid, RspData,
//                   PSEL, PENABLE, PWRITE, PADDR, PWDATA and PSTRB.
//   slave  modport: environment side. This is the fetch requester plus the
//                   SPI APB slave. It drives ReqValid, ReqAddr, RspReady,
//                   PREADY and PRDATA.
//   XLEN: APB data width (32 or 64); only bits [31:0] carry meaning.
interface spi_flash_seq_if #(
  parameter int XLEN = 32
);
  logic              ReqValid;
  logic [23:0]       ReqAddr;
  logic              ReqReady;
  logic              RspValid;
  logic [31:0]       RspData;
  logic              RspReady;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [7:0]        PADDR;
  logic [XLEN-1:0]   PWDATA;
  logic [XLEN/8-1:0] PSTRB;
  logic              PREADY;
  logic [XLEN-1:0]   PRDATA;

  modport master (
    input  ReqValid, ReqAddr, RspReady, PREADY, PRDATA,
    output ReqReady, RspValid, RspData,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );

  modport slave (
    output ReqValid, ReqAddr, RspReady, PREADY, PRDATA,
    input  ReqReady, RspValid, RspData,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );
endinterface

// File: rtl/spi_flash_seq.sv
// spi_flash_seq
//   Hardware read sequencer for the SPI peripheral. It turns one 24-bit flash
//   read request into the full APB register sequence on the SPI block.
//   The sequence is:
//     1. Write CSMODE=HOLD.
//     2. For each byte: write TXDATA with command/address/zero, then poll
//        RXDATA until it is non-empty.
//     3. Write CSMODE=AUTO.
//   It then returns the four data bytes as one little-endian word.
//
//   Ports:
//     PCLK     clock
//     PRESETn  synchronous active-low reset
//     bus      spi_flash_seq_if.master. It carries:
//                - the request handshake (ReqValid/ReqAddr/ReqReady);
//                - the response handshake (RspValid/RspData/RspReady);
//                - the APB master signals (PSEL/PENABLE/PWRITE/PADDR/PWDATA/
//                  PSTRB/PREADY/PRDATA).
//   Parameters:
//     XLEN     APB data width, 32 or 64; must match the interface instance
//     SPIBASE  offset added to every register address on PADDR
//   Build option:
//     SPI_FLASH_FASTREAD_EN  Uses fast read (0x0B) with one dummy byte after
//                            the address. The default build uses normal read
//                            (0x03).
module spi_flash_seq #(
  parameter int         XLEN    = 32,
  parameter logic [7:0] SPIBASE = 8'h00
) (
  input logic             PCLK,
  input logic             PRESETn,
  spi_flash_seq_if.master bus
);

  localparam logic [7:0] CSMODE_OFS  = 8'h18;
  localparam logic [7:0] TXDATA_OFS  = 8'h48;
  localparam logic [7:0] RXDATA_OFS  = 8'h4C;
  localparam logic [7:0] CSMODE_HOLD = 8'h02;
  localparam logic [7:0] CSMODE_AUTO = 8'h00;

`ifdef SPI_FLASH_FASTREAD_EN
  localparam logic [7:0] CMD  = 8'h0B;
  localparam logic [3:0] NHDR = 4'd5;  // cmd + 3 address + 1 dummy
  localparam logic [3:0] NTOT = 4'd9;
`else
  localparam logic [7:0] CMD  = 8'h03;
  localparam logic [3:0] NHDR = 4'd4;  // cmd + 3 address
  localparam logic [3:0] NTOT = 4'd8;
`endif

  typedef enum logic [2:0] {IDLE, CSON, TXB, RXPOLL, GAP, CSOFF, RESP} seqState_t;

  seqState_t   state, nextState;
  logic [23:0] addrReg;
  logic [3:0]  byteIdx;
  logic [31:0] rspData;
  logic        pollEmpty;    // last RXDATA poll returned the empty flag
  logic        accessPhase;  // current APB transfer is past its setup cycle
  logic        apbActive;
  logic        apbDone;
  logic        reqFire;
  logic        rxDone;
  logic [7:0]  txByte;
  logic [7:0]  wrByte;
  logic [1:0]  lane;

  // accessPhase is only ever set inside an APB state, so no state gating needed.
  assign apbDone = accessPhase && bus.PREADY;
  assign reqFire = (state == IDLE) && bus.ReqValid;
  assign rxDone  = (state == RXPOLL) && apbDone;
  assign lane    = 2'(byteIdx - NHDR);
  assign bus.RspData = rspData;

  // The dummy byte (fast read) and all read-out bytes are 0x00.
  always_comb begin
    case (byteIdx)
      4'd0:    txByte = CMD;
      4'd1:    txByte = addrReg[23:16];
      4'd2:    txByte = addrReg[15:8];
      4'd3:    txByte = addrReg[7:0];
      default: txByte = 8'h00;
    endcase
  end

  always_comb begin
    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves one unassigned and no latch is inferred.
    nextState    = state;
    apbActive    = 1'b0;
    wrByte       = 8'h00;
    bus.ReqReady = 1'b0;
    bus.RspValid = 1'b0;
    bus.PWRITE   = 1'b0;
    bus.PADDR    = 8'h00;
    case (state)
      IDLE: begin
        // Held low while reset is asserted, even though state is IDLE.
        bus.ReqReady = PRESETn;
        if (bus.ReqValid) nextState = CSON;
      end
      CSON: begin
        apbActive  = 1'b1;
        bus.PWRITE = 1'b1;
        bus.PADDR  = SPIBASE + CSMODE_OFS;
        wrByte     = CSMODE_HOLD;
        if (apbDone) nextState = TXB;
      end
      TXB: begin
        apbActive  = 1'b1;
        bus.PWRITE = 1'b1;
        bus.PADDR  = SPIBASE + TXDATA_OFS;
        wrByte     = txByte;
        if (apbDone) nextState = RXPOLL;
      end
      RXPOLL: begin
        apbActive = 1'b1;
        bus.PADDR = SPIBASE + RXDATA_OFS;
        if (apbDone) nextState = GAP;
      end
      GAP: begin
        // One bus-idle cycle keeps two RXDATA reads apart.
        if (pollEmpty)           nextState = RXPOLL;
        else if (byteIdx < NTOT) nextState = TXB;
        else                     nextState = CSOFF;
      end
      CSOFF: begin
        apbActive  = 1'b1;
        bus.PWRITE = 1'b1;
        bus.PADDR  = SPIBASE + CSMODE_OFS;
        wrByte     = CSMODE_AUTO;
        if (apbDone) nextState = RESP;
      end
      RESP: begin
        bus.RspValid = 1'b1;
        if (bus.RspReady) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    bus.PSEL    = apbActive;
    bus.PENABLE = apbActive && accessPhase;
    bus.PWDATA  = XLEN'(wrByte);
    bus.PSTRB   = {(XLEN/8){bus.PWRITE}};
  end

  // NOTE: PRESETn is synchronous, so it is tested inside the clocked branch
  // and is not in the sensitivity list. A reset mid-transfer drops PSEL on
  // the next cycle and does not issue a CSOFF write.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state       <= IDLE;
      accessPhase <= 1'b0;
      pollEmpty   <= 1'b0;
      byteIdx     <= 4'd0;
      addrReg     <= 24'h0;
      rspData     <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments make every register here update from
      // pre-edge values, independent of statement order.
      state       <= nextState;
      accessPhase <= apbActive && !apbDone;
      if (reqFire) begin
        addrReg <= bus.ReqAddr;
        byteIdx <= 4'd0;
        rspData <= 32'h0;
      end
      if (rxDone) begin
        pollEmpty <= bus.PRDATA[31];
        if (!bus.PRDATA[31]) begin
          // Bytes clocked in during command/address are echoes; drop them.
          if (byteIdx >= NHDR) rspData[{lane, 3'b000} +: 8] <= bus.PRDATA[7:0];
          byteIdx <= byteIdx + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_seq.sv
`timescale 1ns/1ps
module tb_spi_flash_seq;

  localparam int         XLEN     = 32;
  localparam logic [7:0] SPIBASE  = 8'h20;
  localparam logic [7:0] CSMODE_A = SPIBASE + 8'h18;
  localparam logic [7:0] TXDATA_A = SPIBASE + 8'h48;
  localparam logic [7:0] RXDATA_A = SPIBASE + 8'h4C;
  localparam logic [63:0] NONE    = 64'h1_0000_0000;  // never a legal bus value
`ifdef SPI_FLASH_FASTREAD_EN
  localparam logic [7:0] CMD = 8'h0B;
  localparam int NHDR = 5, NTOT = 9, LAT_MIN = 50;
`else
  localparam logic [7:0] CMD = 8'h03;
  localparam int NHDR = 4, NTOT = 8, LAT_MIN = 45;
`endif

  typedef struct {
    logic [23:0] addr;
    int          waits;
    int          empties;
    int          hold;
    logic [31:0] expData;
    bit          chkLat;
  } vec_t;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  spi_flash_seq_if #(.XLEN(XLEN)) bus();
  spi_flash_seq #(.XLEN(XLEN), .SPIBASE(SPIBASE)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc++;

  int checks = 0, errors = 0;
  logic [7:0]  txQ[$];
  logic [7:0]  csQ[$];
  logic [31:0] rspQ[$];
  logic [7:0]  rxFifo[$];
  logic [7:0]  txBytes[16];
  int waitStates = 0, emptyPolls = 0, waitCnt = 0, emptyLeft = 0;
  int txCount = 0, txSeen = 0, lastRdDone = -10;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Flash contents: 0x100..0x103 hold 11,22,33,44; each 4-byte block above adds a[7:2].
  function automatic logic [7:0] flashByte(input logic [23:0] a);
    logic [7:0] k;
    k = {6'b0, a[1:0]} + 8'd1;
    return (k * 8'h11) + {2'b00, a[7:2]};
  endfunction

  task automatic pushExpect(input logic [23:0] a, input logic [31:0] d);
    csQ.push_back(8'h02);
    csQ.push_back(8'h00);
    txQ.push_back(CMD);
    txQ.push_back(a[23:16]);
    txQ.push_back(a[15:8]);
    txQ.push_back(a[7:0]);
    for (int i = 4; i < NTOT; i++) txQ.push_back(8'h00);
    rspQ.push_back(d);
  endtask

  // APB slave + SPI/flash model: wait states, forced empty polls, RX FIFO fed by TX writes.
  initial begin : apb_slave
    logic [7:0]        sAddr;
    logic              sWrite;
    logic [XLEN-1:0]   sWdata;
    logic [XLEN/8-1:0] sStrb;
    logic [23:0]       fa;
    logic [7:0]        b;
    bus.PREADY = 1'b0;
    bus.PRDATA = '0;
    forever begin
      @(negedge PCLK);
      bus.PREADY = 1'b0;
      bus.PRDATA = 32'h0000_00A5;  // junk outside completion cycles
      if (!PRESETn) begin
        rxFifo.delete();
        txCount = 0;
        waitCnt = 0;
      end else if (bus.PSEL && !bus.PENABLE) begin
        sAddr = bus.PADDR; sWrite = bus.PWRITE; sWdata = bus.PWDATA; sStrb = bus.PSTRB;
        if (!bus.PWRITE && bus.PADDR == RXDATA_A)
          check("rd_gap", 64'((cyc - lastRdDone) >= 2), 64'd1);
      end else if (bus.PSEL && bus.PENABLE) begin
        if (waitCnt < waitStates) begin
          waitCnt++;
        end else begin
          waitCnt = 0;
          bus.PREADY = 1'b1;
          check("apb_stable", {bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PSTRB},
                {sAddr, sWrite, sWdata, sStrb});
          if (bus.PWRITE && bus.PADDR == CSMODE_A) begin
            check("csmode_strb", bus.PSTRB, 4'hF);
            check("csmode", bus.PWDATA, (csQ.size() != 0) ? 64'(csQ.pop_front()) : NONE);
            if (bus.PWDATA == 2) begin
              txCount = 0;
              rxFifo.delete();
              emptyLeft = emptyPolls;
            end
          end else if (bus.PWRITE && bus.PADDR == TXDATA_A) begin
            check("tx_strb", bus.PSTRB, 4'hF);
            check("txdata", bus.PWDATA, (txQ.size() != 0) ? 64'(txQ.pop_front()) : NONE);
            if (txCount < 16) txBytes[txCount] = bus.PWDATA[7:0];
            if (txCount >= NHDR) begin
              fa = {txBytes[1], txBytes[2], txBytes[3]} + 24'(txCount - NHDR);
              b  = flashByte(fa);
            end else begin
              b = 8'hEE;
            end
            rxFifo.push_back(b);
            txCount++;
            txSeen++;
          end else if (bus.PWRITE) begin
            check("wr_addr", bus.PADDR, TXDATA_A);
          end else begin
            check("rd_addr", bus.PADDR, RXDATA_A);
            check("rd_strb", bus.PSTRB, 4'h0);
            lastRdDone = cyc;
            if (emptyLeft > 0) begin
              bus.PRDATA = 32'h8000_005A;
              emptyLeft--;
            end else if (rxFifo.size() != 0) begin
              bus.PRDATA = {24'h0, rxFifo.pop_front()};
              emptyLeft = emptyPolls;
            end else begin
              bus.PRDATA = 32'h8000_0000;
            end
          end
        end
      end
    end
  end

  task automatic runRequest(input vec_t v);
    int c0;
    bit got;
    @(negedge PCLK);
    waitStates = v.waits;
    emptyPolls = v.empties;
    pushExpect(v.addr, v.expData);
    bus.ReqValid = 1'b1;
    bus.ReqAddr  = v.addr;
    check("req_ready_idle", bus.ReqReady, 1);
    c0 = cyc;
    @(negedge PCLK);
    bus.ReqValid = 1'b0;
    check("req_ready_busy", bus.ReqReady, 0);
    got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      if (bus.RspValid) got = 1'b1;
      else @(negedge PCLK);
    end
    check("rsp_arrived", got, 1);
    if (v.chkLat) check("latency", 64'(cyc - c0), 64'(LAT_MIN));
    for (int k = 0; k < v.hold; k++) begin
      bus.ReqValid = (k == v.hold / 2);  // request pulse that must be ignored
      bus.ReqAddr  = 24'h0A0B0C;
      check("hold_rsp_valid", bus.RspValid, 1);
      check("hold_rsp_data", bus.RspData, v.expData);
      check("hold_req_ready", bus.ReqReady, 0);
      @(negedge PCLK);
    end
    bus.ReqValid = 1'b0;
    bus.RspReady = 1'b1;
    check("rsp_valid", bus.RspValid, 1);
    check("rsp_data", bus.RspData, (rspQ.size() != 0) ? 64'(rspQ.pop_front()) : NONE);
    @(negedge PCLK);
    bus.RspReady = 1'b0;
    check("post_rsp_valid", bus.RspValid, 0);
    check("post_req_ready", bus.ReqReady, 1);
  endtask

  task automatic resetMidSequence();
    int base;
    bit hit;
    @(negedge PCLK);
    waitStates = 0;
    emptyPolls = 0;
    pushExpect(24'h000100, 32'h44332211);
    bus.ReqValid = 1'b1;
    bus.ReqAddr  = 24'h000100;
    base = txSeen;
    @(negedge PCLK);
    bus.ReqValid = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      if (txSeen - base >= 5) hit = 1'b1;
      else @(negedge PCLK);
    end
    check("mid_reach_byte5", hit, 1);
    PRESETn = 1'b0;
    @(negedge PCLK);
    check("mid_rst_psel", bus.PSEL, 0);
    check("mid_rst_penable", bus.PENABLE, 0);
    check("mid_rst_rsp_valid", bus.RspValid, 0);
    check("mid_rst_req_ready", bus.ReqReady, 0);
    txQ.delete();
    csQ.delete();
    rspQ.delete();
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("mid_idle_req_ready", bus.ReqReady, 1);
    check("mid_idle_psel", bus.PSEL, 0);
  endtask

  initial begin : main
    vec_t vecs[5];
    vec_t after;
    vecs[0] = '{24'h000100, 0, 0, 0,  32'h44332211, 1'b1};
    vecs[1] = '{24'h000100, 2, 3, 0,  32'h44332211, 1'b0};
    vecs[2] = '{24'h000102, 0, 0, 10, 32'h23124433, 1'b1};
    vecs[3] = '{24'hFFFFFE, 1, 1, 0,  32'h22118372, 1'b0};
    vecs[4] = '{24'h123458, 0, 2, 0,  32'h5A493827, 1'b0};
    after   = '{24'hFFFFFC, 0, 0, 0,  32'h83726150, 1'b1};

    bus.ReqValid = 1'b0;
    bus.ReqAddr  = 24'h0;
    bus.RspReady = 1'b0;
    PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    check("rst_req_ready", bus.ReqReady, 0);
    check("rst_rsp_valid", bus.RspValid, 0);
    check("rst_rsp_data", bus.RspData, 0);
    check("rst_psel", bus.PSEL, 0);
    check("rst_penable", bus.PENABLE, 0);
    check("rst_pwrite", bus.PWRITE, 0);
    check("rst_paddr", bus.PADDR, 0);
    check("rst_pwdata", bus.PWDATA, 0);
    check("rst_pstrb", bus.PSTRB, 0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("idle_req_ready", bus.ReqReady, 1);

    for (int i = 0; i < 5; i++) runRequest(vecs[i]);
    resetMidSequence();
    runRequest(after);

    repeat (3) @(negedge PCLK);
    check("sb_tx_drained", 64'(txQ.size()), 64'd0);
    check("sb_cs_drained", 64'(csQ.size()), 64'd0);
    check("sb_rsp_drained", 64'(rspQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
